inst_fetch: RTL
===============

Name: inst_fetch

Overview:
Instruction fetch stage directly downstream of the program counter. It consumes the current PC, issues one word-addressed read to instruction memory and buffers returned instructions with their PC in a 2-entry queue for decode. It also generates the PC's next value and update-enable: sequential increment or branch/jump redirect. Redirects flush the queue and discard any in-flight response.

Parameters:
CONTENT_SIZE, 16, PC / instruction-memory address width (word address)
INST_SIZE, 32, instruction word width

Ports:
clk  input  1  clock
rst  input  1  reset
pc  input  CONTENT_SIZE  current PC from program counter
pc_enable  output  1  PC update enable (combinational)
next_pc  output  CONTENT_SIZE  value loaded into PC when pc_enable=1 (combinational)
redirect_valid  input  1  branch/jump taken; flush and restart
redirect_pc  input  CONTENT_SIZE  redirect target
imem_req  output  1  read request (registered)
imem_addr  output  CONTENT_SIZE  read address (registered)
imem_ack  input  1  one-cycle pulse; imem_rdata valid in this cycle
imem_rdata  input  INST_SIZE  instruction data
inst_valid  output  1  queue head valid
inst_ready  input  1  decode accepts head
inst  output  INST_SIZE  queue head instruction
inst_pc  output  CONTENT_SIZE  PC of queue head

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock is clk, reset is rst (rst=0 resets).
- Reset values: state IDLE, queue count 0, imem_req 0, imem_addr 0, inst_valid 0, inst 0, inst_pc 0. pc_enable is 0 while in reset. next_pc = pc+1.
- States: IDLE, WAIT, DROP. At most one outstanding request.
- IDLE:
  - If redirect_valid=0 and count<2 (registered count), go to WAIT next edge with imem_req<=1 and imem_addr<=pc.
  - Otherwise stay IDLE with imem_req=0.
- WAIT:
  - imem_req and imem_addr are held stable until imem_ack.
  - On ack without redirect: push {pc=imem_addr, imem_rdata}, assert pc_enable with next_pc=imem_addr+1, and go to IDLE. imem_req<=0.
  - Minimum issue-to-issue spacing is 2 cycles.
- DROP: a redirect arrived while waiting.
  - imem_req is held until imem_ack; the response is discarded with no push and no pc_enable.
  - On ack go to IDLE.
- Redirect has priority over all other events, in any state:
  - pc_enable=1, next_pc=redirect_pc.
  - Queue flushed (count<=0), including any same-cycle pop or push.
  - WAIT without ack -> DROP. WAIT with ack -> IDLE, data dropped. IDLE stays IDLE with no issue this cycle. DROP stays DROP, or goes to IDLE if ack; the latest redirect wins.
- Address arithmetic: next_pc = imem_addr+1 modulo 2^CONTENT_SIZE (0xFFFF+1=0x0000). No carry out.
- Queue:
  - inst_valid = count!=0. inst and inst_pc come from the head entry.
  - Pop on inst_valid & inst_ready. Push and pop in the same cycle are both honoured.
  - Entries are delivered in fetch order. Output values are unchanged while inst_valid=1 and inst_ready=0.
- imem_ack outside WAIT/DROP is ignored.
- Asynchronous reset mid-WAIT or mid-DROP returns to IDLE immediately, drops the request and clears the queue. The memory must also be reset.

Test Plan:
- Reset release with pc=0 and memory acking 1 cycle after req:
  - imem_req=1, imem_addr=0x0000 one cycle after release.
  - On the ack cycle pc_enable=1, next_pc=0x0001.
  - Next cycle inst_valid=1, inst_pc=0x0000, inst=rdata.
- Backpressure, inst_ready=0 with pcs 0,1 fetched:
  - count=2, imem_req stays 0.
  - Raise inst_ready: pops inst_pc 0 then 1, and fetch of pc 2 resumes.
- redirect_valid=1, redirect_pc=0x0040 in WAIT, ack 3 cycles later:
  - DROP state, imem_req held at the old addr.
  - Ack causes no push. Next request has imem_addr=0x0040.
- Redirect in the same cycle as imem_ack, with 1 entry queued:
  - No push, count=0.
  - pc_enable=1, next_pc=redirect_pc.
  - Next request goes to redirect_pc.
- pc=0xFFFF fetched -> on ack next_pc=0x0000, inst_pc=0xFFFF.
- rst driven low asynchronously mid-WAIT -> imem_req=0, inst_valid=0 and count=0 before the next clock edge.

Source files
------------

// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - fetch-stage bundle: PC update, imem read port and decode-side instruction stream.
interface inst_fetch_if #(
  parameter int CONTENT_SIZE = 16,
  parameter int INST_SIZE    = 32
);
  logic [CONTENT_SIZE-1:0] pc;
  logic                    pc_enable;
  logic [CONTENT_SIZE-1:0] next_pc;
  logic                    redirect_valid;
  logic [CONTENT_SIZE-1:0] redirect_pc;
  logic                    imem_req;
  logic [CONTENT_SIZE-1:0] imem_addr;
  logic                    imem_ack;
  logic [INST_SIZE-1:0]    imem_rdata;
  logic                    inst_valid;
  logic                    inst_ready;
  logic [INST_SIZE-1:0]    inst;
  logic [CONTENT_SIZE-1:0] inst_pc;

  modport master (
    input  pc, redirect_valid, redirect_pc, imem_ack, imem_rdata, inst_ready,
    output pc_enable, next_pc, imem_req, imem_addr, inst_valid, inst, inst_pc
  );

  modport slave (
    output pc, redirect_valid, redirect_pc, imem_ack, imem_rdata, inst_ready,
    input  pc_enable, next_pc, imem_req, imem_addr, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - single-outstanding instruction fetch with 2-entry decode queue and PC redirect.
module inst_fetch #(
  parameter int CONTENT_SIZE = 16,
  parameter int INST_SIZE    = 32
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus
);
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              count_q, count_d;
  logic                    head_q, head_d;
  logic                    imem_req_q, imem_req_d;
  logic [CONTENT_SIZE-1:0] imem_addr_q, imem_addr_d;
  logic [CONTENT_SIZE-1:0] qpc_q [2];
  logic [CONTENT_SIZE-1:0] qpc_d [2];
  logic [INST_SIZE-1:0]    qinst_q [2];
  logic [INST_SIZE-1:0]    qinst_d [2];

  logic push, pop, ack_wait, wr_slot;

  always_comb begin
    ack_wait = (state_q == WAIT) && bus.imem_ack;
    push     = ack_wait && !bus.redirect_valid;
    pop      = (count_q != 2'd0) && bus.inst_ready;
    wr_slot  = head_q ^ count_q[0];

    state_d     = state_q;
    imem_req_d  = imem_req_q;
    imem_addr_d = imem_addr_q;
    qpc_d       = qpc_q;
    qinst_d     = qinst_q;

    if (push) begin
      qpc_d[wr_slot]   = imem_addr_q;
      qinst_d[wr_slot] = bus.imem_rdata;
    end

    // A redirect flushes everything, overriding any same-cycle push or pop.
    if (bus.redirect_valid) begin
      count_d = 2'd0;
      head_d  = 1'b0;
    end else begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      head_d  = head_q ^ pop;
    end

    case (state_q)
      IDLE: begin
        if (!bus.redirect_valid && (count_q < 2'd2)) begin
          state_d     = WAIT;
          imem_req_d  = 1'b1;
          imem_addr_d = bus.pc;
        end else begin
          imem_req_d = 1'b0;
        end
      end
      WAIT: begin
        if (bus.imem_ack) begin
          state_d    = IDLE;
          imem_req_d = 1'b0;
        end else if (bus.redirect_valid) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (bus.imem_ack) begin
          state_d    = IDLE;
          imem_req_d = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        imem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      count_q     <= 2'd0;
      head_q      <= 1'b0;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      for (int i = 0; i < 2; i++) begin
        qpc_q[i]   <= '0;
        qinst_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      head_q      <= head_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      qpc_q       <= qpc_d;
      qinst_q     <= qinst_d;
    end
  end

  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.inst_valid = (count_q != 2'd0);
  assign bus.inst       = qinst_q[head_q];
  assign bus.inst_pc    = qpc_q[head_q];

  // Gated by rst so the PC register never loads while the stage is held in reset.
  assign bus.pc_enable = rst && (bus.redirect_valid || push);
  assign bus.next_pc   = bus.redirect_valid ? bus.redirect_pc :
                         push               ? imem_addr_q + CONTENT_SIZE'(1) :
                                              bus.pc + CONTENT_SIZE'(1);
endmodule
